// File: rtl/disp_pkg.sv
// Shared constants for the display conditioning stage.
// Digit indices, nibble positions and blink defaults.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 4;

    localparam int DIG3 = 3;
    localparam int DIG2 = 2;
    localparam int DIG1 = 1;
    localparam int DIG0 = 0;

    localparam int NIB3_LSB = DIG3 * DIG_W;
    localparam int NIB2_LSB = DIG2 * DIG_W;
    localparam int NIB1_LSB = DIG1 * DIG_W;
    localparam int NIB0_LSB = DIG0 * DIG_W;

    localparam logic BLANK_ON = 1'b1;

    localparam int DEFAULT_HALF_PERIOD = 12_500_000;

endpackage

// File: rtl/blink_prescaler.sv
// Blink half-period prescaler with phase flag.
// A restart forces the ON phase and clears the count.
module blink_prescaler
    import disp_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase,
    output logic phase_next
);

    localparam int CNT_W =
        (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Restart takes priority over a coincident terminal count.
    always_comb begin
        cnt_next   = cnt + CNT_W'(1);
        phase_next = phase;
        if (restart) begin
            cnt_next   = '0;
            phase_next = 1'b1;
        end else if (cnt == TC) begin
            cnt_next   = '0;
            phase_next = ~phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/disp_blink_mod.sv
// Registers the BCD digit word and builds the per-digit blank
// vector from blink selection and leading-zero suppression.
module disp_blink_mod
    import disp_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blink_mask,
    input  logic        lz_en,
    output logic [15:0] digits_out,
    output logic [3:0]  blank,
    output logic        phase
);

    logic [3:0] mask_q;
    logic [3:0] lz;
    logic [3:0] blank_next;
    logic       restart;
    logic       phase_next;

    assign restart = (blink_mask != mask_q);

    blink_prescaler #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .phase      (phase),
        .phase_next (phase_next)
    );

    // Zero suppression runs left to right and never reaches digit 0.
    always_comb begin
        lz       = '0;
        lz[DIG3] = lz_en
                 & (digits_in[NIB3_LSB +: DIG_W] == '0);
        lz[DIG2] = lz[DIG3]
                 & (digits_in[NIB2_LSB +: DIG_W] == '0);
        lz[DIG1] = lz[DIG2]
                 & (digits_in[NIB1_LSB +: DIG_W] == '0);
        lz[DIG0] = 1'b0;
    end

    always_comb begin
        blank_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank_next[i] =
                ((blink_mask[i] & ~phase_next) | lz[i])
                ? BLANK_ON : ~BLANK_ON;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            digits_out <= '0;
            blank      <= '0;
        end else begin
            mask_q     <= blink_mask;
            digits_out <= digits_in;
            blank      <= blank_next;
        end
    end

endmodule
